exp_pos_eval: RTL and testbench
===============================

Name: exp_pos_eval

Overview:
- Evaluates one 4-input Boolean function F(a,b,c,d) in two independent forms:
  - exp: a sum-of-products expression.
  - pos: a product-of-sums expression.
- Registers both results.
- Flags any disagreement between the two forms.
- Tracks which of the 16 input combinations have been applied, so a sweep can be declared complete.
- Used as a self-checking combinational-logic cell in lab and verification fixtures.

Parameters:
- FUNC_TT, default 16'h0727: truth table of F. Bit i is F for {a,b,c,d} = i, with a as MSB. Default is F = Σm(0,1,2,5,8,9,10) = b'd' + b'c' + a'c'd = (a'+b')(c'+d')(b'+d).

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: synchronous reset, active-high.
- en, input, 1: sample enable; when low, all registers hold.
- a, input, 1: function input, MSB of the index.
- b, input, 1: function input.
- c, input, 1: function input.
- d, input, 1: function input, LSB of the index.
- f_e, output, 1: registered result of the SOP form.
- f_p, output, 1: registered result of the POS form.
- mismatch, output, 1: registered flag, f_e != f_p for the sampled vector.
- seen, output, 16: bit i set once index i has been sampled since reset.
- sweep_done, output, 1: high when seen == 16'hFFFF.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Index: idx = {a,b,c,d}, 0..15.
- SOP path:
  - OR over all i with FUNC_TT[i] = 1 of the minterm m_i(a,b,c,d).
  - If FUNC_TT = 0, the SOP path is constant 0.
- POS path:
  - AND over all i with FUNC_TT[i] = 0 of the maxterm M_i(a,b,c,d).
  - If FUNC_TT = 16'hFFFF, the POS path is constant 1.
- The two paths are generated separately from FUNC_TT. Neither may be derived from the other or from a direct FUNC_TT[idx] lookup.
- Reset (rst = 1 at a rising edge):
  - f_e, f_p, mismatch, sweep_done = 0; seen = 16'h0000.
  - Reset has priority over en.
  - Reset mid-sweep discards all coverage.
- Sample (rst = 0, en = 1):
  - f_e <= SOP(idx); f_p <= POS(idx); mismatch <= SOP(idx) ^ POS(idx).
  - seen[idx] <= 1.
  - sweep_done <= ((seen | onehot(idx)) == 16'hFFFF).
- Hold (rst = 0, en = 0): all outputs retain their values.
- Latency:
  - Inputs sampled at edge N appear on the outputs after edge N; one cycle of latency.
  - Inputs are treated as settled before each edge. No internal synchronisers.
- seen is sticky:
  - Repeated indices change nothing.
  - Order of application is irrelevant.
  - sweep_done stays high until reset.
- mismatch is per-sample, not sticky. For any correct implementation it is 0 in every cycle.
- No X propagation from outputs after the first reset.

Test Plan:
- Reset: assert rst for 2 cycles with random a–d and en = 1 -> f_e = f_p = mismatch = sweep_done = 0, seen = 16'h0000.
- Exhaustive sweep, default FUNC_TT:
  - Stimulus: en = 1, idx = 0..15 one per cycle.
  - f_e = f_p sequence 1,1,1,0,0,1,0,0,1,1,1,0,0,0,0,0.
  - mismatch = 0 throughout.
  - sweep_done rises on the cycle after idx 15 is sampled, with seen = 16'hFFFF.
- Enable hold: sample idx = 5 (f_e = 1), then drop en and apply idx = 4 for 3 cycles -> f_e = f_p = 1 held; seen unchanged (bit 5 only, 16'h0020).
- Reset mid-sweep:
  - Sweep idx 0..9, then pulse rst -> seen = 0, sweep_done = 0.
  - Resume with idx 10..15 -> seen = 16'hFC00, sweep_done = 0.
- Out-of-order coverage: apply idx 15 down to 0, with idx 3 repeated twice -> sweep_done = 1 only after the final new index; seen = 16'hFFFF.
- Parameter overrides:
  - FUNC_TT = 16'h8000 (a·b·c·d): f_e = f_p = 1 only for idx 15.
  - FUNC_TT = 16'h0000: both outputs 0 for all idx.
  - FUNC_TT = 16'hFFFF: both outputs 1 for all idx.
  - mismatch = 0 in all three cases.

Source files
------------

// File: rtl/exp_pos_eval.sv
// rtl/exp_pos_eval.sv - registered SOP/POS evaluation of a 4-input function with agreement flag and index coverage
module exp_pos_eval #(
    parameter logic [15:0] FUNC_TT = 16'h0727
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    output logic        f_e,
    output logic        f_p,
    output logic        mismatch,
    output logic [15:0] seen,
    output logic        sweep_done
);

    logic [3:0]  idx;
    logic [15:0] minterm;
    logic [15:0] maxterm;
    logic        sop;
    logic        pos;
    logic [15:0] onehot;
    logic [15:0] seen_next;

    assign idx = {a, b, c, d};

    // Each term is built from literals of a..d so the two forms stay
    // structurally independent of each other and of a table lookup.
    for (genvar i = 0; i < 16; i++) begin : g_terms
        localparam logic [3:0] IV = 4'(i);
        assign minterm[i] = (IV[3] ? a : ~a) & (IV[2] ? b : ~b)
                          & (IV[1] ? c : ~c) & (IV[0] ? d : ~d);
        assign maxterm[i] = (IV[3] ? ~a : a) | (IV[2] ? ~b : b)
                          | (IV[1] ? ~c : c) | (IV[0] ? ~d : d);
    end

    // Unselected minterms are masked to 0, unselected maxterms forced to 1,
    // which also yields the constant-0 SOP / constant-1 POS corner cases.
    assign sop = |(minterm & FUNC_TT);
    assign pos = &(maxterm | FUNC_TT);

    assign onehot    = 16'd1 << idx;
    assign seen_next = seen | onehot;

    always_ff @(posedge clk) begin
        if (rst) begin
            f_e        <= 1'b0;
            f_p        <= 1'b0;
            mismatch   <= 1'b0;
            seen       <= 16'h0000;
            sweep_done <= 1'b0;
        end else if (en) begin
            f_e        <= sop;
            f_p        <= pos;
            mismatch   <= sop ^ pos;
            seen       <= seen_next;
            sweep_done <= &seen_next;
        end
    end

endmodule

// File: tb/tb_exp_pos_eval.sv
// tb/tb_exp_pos_eval.sv - scoreboard bench for exp_pos_eval across default and overridden truth tables
module tb_exp_pos_eval;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;

    logic        fe0, fp0, mm0, done0;
    logic [15:0] seen0;
    logic        fe1, fp1, mm1, done1;
    logic [15:0] seen1;
    logic        fe2, fp2, mm2, done2;
    logic [15:0] seen2;
    logic        fe3, fp3, mm3, done3;
    logic [15:0] seen3;

    always #5 clk = ~clk;

    exp_pos_eval u_dut (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d),
        .f_e(fe0), .f_p(fp0), .mismatch(mm0), .seen(seen0), .sweep_done(done0)
    );
    exp_pos_eval #(.FUNC_TT(16'h8000)) u_and (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d),
        .f_e(fe1), .f_p(fp1), .mismatch(mm1), .seen(seen1), .sweep_done(done1)
    );
    exp_pos_eval #(.FUNC_TT(16'h0000)) u_zero (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d),
        .f_e(fe2), .f_p(fp2), .mismatch(mm2), .seen(seen2), .sweep_done(done2)
    );
    exp_pos_eval #(.FUNC_TT(16'hFFFF)) u_one (
        .clk(clk), .rst(rst), .en(en), .a(a), .b(b), .c(c), .d(d),
        .f_e(fe3), .f_p(fp3), .mismatch(mm3), .seen(seen3), .sweep_done(done3)
    );

    typedef struct {
        int          idx;
        logic        f;
        logic [15:0] seen;
        logic        done;
        logic        f_and;
        logic        f_zero;
        logic        f_one;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Hand-derived F for idx 0..15 with the default truth table.
    logic hand_f [0:15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                            1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    logic        m_f = 1'b0, m_and = 1'b0, m_zero = 1'b0, m_one = 1'b0;
    logic [15:0] m_seen = 16'h0000;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want, input int idx);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s idx=%0d got=%h expected=%h", name, idx, got, want);
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] i);
        exp_t x;
        @(negedge clk);
        rst = r;
        en  = e;
        {a, b, c, d} = i;
        @(posedge clk);
        #1;
        if (r) begin
            m_seen = 16'h0000;
            m_f = 1'b0; m_and = 1'b0; m_zero = 1'b0; m_one = 1'b0;
        end else if (e) begin
            m_seen = m_seen | (16'd1 << i);
            m_f    = hand_f[i];
            m_and  = (i == 4'd15);
            m_zero = 1'b0;
            m_one  = 1'b1;
        end
        x.idx = int'(i); x.f = m_f; x.seen = m_seen; x.done = (m_seen == 16'hFFFF);
        x.f_and = m_and; x.f_zero = m_zero; x.f_one = m_one;
        q.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("f_e",        16'(fe0),   16'(e.f),    e.idx);
            chk("f_p",        16'(fp0),   16'(e.f),    e.idx);
            chk("mismatch",   16'(mm0),   16'h0,       e.idx);
            chk("seen",       seen0,      e.seen,      e.idx);
            chk("sweep_done", 16'(done0), 16'(e.done), e.idx);
            chk("and_f_e",    16'(fe1),   16'(e.f_and),  e.idx);
            chk("and_f_p",    16'(fp1),   16'(e.f_and),  e.idx);
            chk("zero_f_e",   16'(fe2),   16'(e.f_zero), e.idx);
            chk("zero_f_p",   16'(fp2),   16'(e.f_zero), e.idx);
            chk("one_f_e",    16'(fe3),   16'(e.f_one),  e.idx);
            chk("one_f_p",    16'(fp3),   16'(e.f_one),  e.idx);
            chk("ovr_mismatch", 16'({mm1, mm2, mm3}), 16'h0, e.idx);
        end
    end

    initial begin
        // reset with random inputs and en high: reset must win
        step(1'b1, 1'b1, 4'($urandom_range(0, 15)));
        step(1'b1, 1'b1, 4'($urandom_range(0, 15)));

        // exhaustive ascending sweep
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i));
        // done must hold through a repeated index and a disabled cycle
        step(1'b0, 1'b1, 4'd7);
        step(1'b0, 1'b0, 4'd3);

        // enable hold
        step(1'b1, 1'b1, 4'd0);
        step(1'b0, 1'b1, 4'd5);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 4'd4);

        // reset mid-sweep discards coverage
        step(1'b1, 1'b1, 4'd0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 4'(i));
        step(1'b1, 1'b1, 4'd12);
        for (int i = 10; i < 16; i++) step(1'b0, 1'b1, 4'(i));

        // descending coverage with index 3 repeated
        step(1'b1, 1'b0, 4'd9);
        for (int i = 15; i >= 4; i--) step(1'b0, 1'b1, 4'(i));
        step(1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b1, 4'd3);
        step(1'b0, 1'b1, 4'd2);
        step(1'b0, 1'b1, 4'd1);
        step(1'b0, 1'b1, 4'd0);

        repeat (3) @(negedge clk);
        n_checks++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain pending=%0d expected=0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
